// File: rtl/tlp_rx_engine.sv
// Receive-side decoder: turns single-DW MemRd/MemWr TLPs from the PCIe RX stream into
// write strobes or held read requests for mem_access; all other TLPs are drained.
module tlp_rx_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] m_axis_rx_tdata,
    input  logic [7:0]  m_axis_rx_tkeep,
    input  logic        m_axis_rx_tlast,
    input  logic        m_axis_rx_tvalid,
    output logic        m_axis_rx_tready,
    input  logic [21:0] m_axis_rx_tuser,
    output logic [13:0] rd_addr,
    output logic [3:0]  rd_be,
    output logic        wr_en,
    output logic [7:0]  wr_be,
    output logic [13:0] wr_addr,
    output logic [31:0] wr_data,
    input  logic        wr_busy,
    output logic        req_compl,
    input  logic        compl_done,
    output logic [2:0]  req_tc,
    output logic        req_td,
    output logic        req_ep,
    output logic [1:0]  req_attr,
    output logic [9:0]  req_len,
    output logic [15:0] req_rid,
    output logic [7:0]  req_tag,
    output logic [7:0]  req_be,
    output logic [12:0] req_addr
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RD32     = 4'd1,
        S_RD64     = 4'd2,
        S_WR32     = 4'd3,
        S_WR64A    = 4'd4,
        S_WR64B    = 4'd5,
        S_WAIT_WR  = 4'd6,
        S_WAIT_CPL = 4'd7,
        S_DISCARD  = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_tready;
    logic        r_wr_en;
    logic        r_req_compl;
    logic [1:0]  r_region;
    logic [13:0] r_rd_addr;
    logic [3:0]  r_rd_be;
    logic [13:0] r_wr_addr;
    logic [7:0]  r_wr_be;
    logic [31:0] r_wr_data;
    logic [2:0]  r_req_tc;
    logic        r_req_td;
    logic        r_req_ep;
    logic [1:0]  r_req_attr;
    logic [9:0]  r_req_len;
    logic [15:0] r_req_rid;
    logic [7:0]  r_req_tag;
    logic [7:0]  r_req_be;
    logic [12:0] r_req_addr;

    logic        w_beat;
    logic        w_hdr_ok;
    logic [1:0]  w_fmt;
    logic [1:0]  w_region;
    logic [11:0] w_addr_dw;
    logic        w_unused;

    function automatic logic [31:0] swap_bytes(input logic [31:0] d);
        swap_bytes = {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic ready_in(input state_t s);
        case (s)
            S_WAIT_WR, S_WAIT_CPL: ready_in = 1'b0;
            default:               ready_in = 1'b1;
        endcase
    endfunction

    assign w_beat    = m_axis_rx_tvalid & r_tready;
    assign w_fmt     = m_axis_rx_tdata[30:29];
    assign w_hdr_ok  = (m_axis_rx_tdata[28:24] == 5'b00000) && (m_axis_rx_tdata[9:0] == 10'd1);
    assign w_region  = m_axis_rx_tuser[2] ? 2'b01 : (m_axis_rx_tuser[4] ? 2'b10 : 2'b00);
    // 64-bit address formats carry the low address DW in the upper half of the beat.
    assign w_addr_dw = ((r_state == S_RD64) || (r_state == S_WR64A)) ?
                       m_axis_rx_tdata[45:34] : m_axis_rx_tdata[13:2];
    assign w_unused  = ^{m_axis_rx_tkeep, m_axis_rx_tuser[21:5], m_axis_rx_tuser[3],
                         m_axis_rx_tuser[1:0]};

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_beat && !m_axis_rx_tlast) begin
                    if (w_hdr_ok) begin
                        case (w_fmt)
                            2'b00:   w_next = S_RD32;
                            2'b01:   w_next = S_RD64;
                            2'b10:   w_next = S_WR32;
                            default: w_next = S_WR64A;
                        endcase
                    end else begin
                        w_next = S_DISCARD;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RD32, S_RD64: begin
                if (w_beat) w_next = S_WAIT_CPL;
                else        w_next = r_state;
            end
            S_WR32, S_WR64B: begin
                if (w_beat) w_next = S_WAIT_WR;
                else        w_next = r_state;
            end
            S_WR64A: begin
                if (w_beat) w_next = m_axis_rx_tlast ? S_IDLE : S_WR64B;
                else        w_next = S_WR64A;
            end
            S_WAIT_WR: begin
                if (!wr_busy) w_next = S_IDLE;
                else          w_next = S_WAIT_WR;
            end
            S_WAIT_CPL: begin
                if (compl_done) w_next = S_IDLE;
                else            w_next = S_WAIT_CPL;
            end
            S_DISCARD: begin
                if (w_beat && m_axis_rx_tlast) w_next = S_IDLE;
                else                           w_next = S_DISCARD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register; tready/wr_en/req_compl are registered decodes of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tready    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_req_compl <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_tready    <= ready_in(w_next);
            r_wr_en     <= (w_next == S_WAIT_WR);
            r_req_compl <= (w_next == S_WAIT_CPL);
        end
    end

    // Header, address and data capture; read-side fields only change when a new request decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_region   <= 2'b00;
            r_rd_addr  <= 14'd0;
            r_rd_be    <= 4'd0;
            r_wr_addr  <= 14'd0;
            r_wr_be    <= 8'd0;
            r_wr_data  <= 32'd0;
            r_req_tc   <= 3'd0;
            r_req_td   <= 1'b0;
            r_req_ep   <= 1'b0;
            r_req_attr <= 2'd0;
            r_req_len  <= 10'd0;
            r_req_rid  <= 16'd0;
            r_req_tag  <= 8'd0;
            r_req_be   <= 8'd0;
            r_req_addr <= 13'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_beat && w_hdr_ok && !m_axis_rx_tlast) begin
                        r_region   <= w_region;
                        r_req_tc   <= m_axis_rx_tdata[22:20];
                        r_req_td   <= m_axis_rx_tdata[15];
                        r_req_ep   <= m_axis_rx_tdata[14];
                        r_req_attr <= m_axis_rx_tdata[13:12];
                        r_req_len  <= m_axis_rx_tdata[9:0];
                        r_req_rid  <= m_axis_rx_tdata[63:48];
                        r_req_tag  <= m_axis_rx_tdata[47:40];
                        r_req_be   <= m_axis_rx_tdata[39:32];
                    end
                end
                S_RD32, S_RD64: begin
                    if (w_beat) begin
                        r_rd_addr  <= {r_region, w_addr_dw};
                        r_rd_be    <= r_req_be[3:0];
                        r_req_addr <= {w_addr_dw[10:0], 2'b00};
                    end
                end
                S_WR32: begin
                    if (w_beat) begin
                        r_wr_addr <= {r_region, w_addr_dw};
                        r_wr_be   <= r_req_be;
                        r_wr_data <= swap_bytes(m_axis_rx_tdata[63:32]);
                    end
                end
                S_WR64A: begin
                    if (w_beat) begin
                        r_wr_addr <= {r_region, w_addr_dw};
                    end
                end
                S_WR64B: begin
                    if (w_beat) begin
                        r_wr_be   <= r_req_be;
                        r_wr_data <= swap_bytes(m_axis_rx_tdata[31:0]);
                    end
                end
                default: begin
                    r_region <= r_region;
                end
            endcase
        end
    end

    assign m_axis_rx_tready = r_tready;
    assign wr_en            = r_wr_en;
    assign req_compl        = r_req_compl;
    assign rd_addr          = r_rd_addr;
    assign rd_be            = r_rd_be;
    assign wr_addr          = r_wr_addr;
    assign wr_be            = r_wr_be;
    assign wr_data          = r_wr_data;
    assign req_tc           = r_req_tc;
    assign req_td           = r_req_td;
    assign req_ep           = r_req_ep;
    assign req_attr         = r_req_attr;
    assign req_len          = r_req_len;
    assign req_rid          = r_req_rid;
    assign req_tag          = r_req_tag;
    assign req_be           = r_req_be;
    assign req_addr         = r_req_addr;

endmodule

// File: doc/tlp_rx_engine.md
# tlp_rx_engine

Receive-side request decoder between the 7-series PCIe core's 64-bit AXI4-Stream RX interface and the `mem_access` register/BRAM block. It accepts single-DW MemRd/MemWr TLPs (32- and 64-bit addressing) targeting BAR0 or BAR2. It converts each request into either a one-cycle write strobe or a held read address plus a completion request to the TX engine. All other TLPs are consumed and dropped.

## Interface
- No parameters.
- `clk`  in  1  user clock from the PCIe core.
- `rst`  in  1  asynchronous reset, active-high.
- `m_axis_rx_tdata`  in  64  RX beat; DW0 in [31:0], DW1 in [63:32].
- `m_axis_rx_tkeep`  in  8  byte valid; informational only.
- `m_axis_rx_tlast`  in  1  last beat of TLP.
- `m_axis_rx_tvalid`  in  1  beat valid.
- `m_axis_rx_tready`  out  1  beat accepted when tvalid&tready.
- `m_axis_rx_tuser`  in  22  core sideband; bar-hit in [8:2] (bit 2 = BAR0, bit 4 = BAR2).
- `rd_addr`  out  14  {region[1:0], DW address[11:0]} to mem_access.
- `rd_be`  out  4  first-DW byte enables of the read.
- `wr_en`  out  1  write strobe.
- `wr_be`  out  8  {lastBE, firstBE}.
- `wr_addr`  out  14  same format as rd_addr.
- `wr_data`  out  32  byte-swapped write DW.
- `wr_busy`  in  1  write sink stall.
- `req_compl`  out  1  completion request, held until compl_done.
- `compl_done`  in  1  single-cycle pulse from the TX engine.
- `req_tc`  out  3  TLP traffic class.
- `req_td`  out  1  TLP digest bit.
- `req_ep`  out  1  TLP poisoned bit.
- `req_attr`  out  2  TLP attributes.
- `req_len`  out  10  TLP length field.
- `req_rid`  out  16  requester ID.
- `req_tag`  out  8  TLP tag.
- `req_be`  out  8  {lastBE, firstBE}.
- `req_addr`  out  13  {TLP addr[12:2], 2'b00}.

## Operation
- States: IDLE, RD32, RD64, WR32, WR64A, WR64B, WAIT_WR, WAIT_CPL, DISCARD.
- Header fields from beat 0:
  - fmt = [30:29], type = [28:24], TC = [22:20], TD = [15], EP = [14], Attr = [13:12], length = [9:0].
  - RID = [63:48], tag = [47:40], lastBE = [39:36], firstBE = [35:32].
- Region from bar-hit: BAR0 → 2'b01, BAR2 → 2'b10, otherwise 2'b00.
- IDLE transitions on an accepted beat with type = 5'b00000 and length = 1:
  - fmt 00 → RD32.
  - fmt 01 → RD64.
  - fmt 10 → WR32.
  - fmt 11 → WR64A.
  - Anything else: DISCARD if tlast = 0, otherwise stay in IDLE.
  - Header fields and region are latched on this beat.
- RD32: beat 1 [31:0] is the address.
  - Load rd_addr = {region, addr[13:2]}, rd_be = firstBE, req_addr.
  - Assert req_compl; go to WAIT_CPL.
- RD64: beat 1 [63:32] is the low address; otherwise identical to RD32.
- WR32: beat 1 [31:0] is the address, [63:32] is the data.
  - Load wr_addr, wr_be, and wr_data = {d[7:0], d[15:8], d[23:16], d[31:24]}; go to WAIT_WR.
- WR64A: beat 1 [63:32] is the low address; go to WR64B.
- WR64B: beat 2 [31:0] is the data; load as in WR32; go to WAIT_WR.
- WAIT_WR: wr_en = 1 while in this state; leave to IDLE on the first cycle with wr_busy = 0.
- WAIT_CPL: req_compl = 1 and all req_* fields plus rd_addr/rd_be stay stable; leave to IDLE on compl_done.
- DISCARD: consume beats until an accepted beat has tlast = 1, then go to IDLE.
- rd_addr/rd_be keep their last value until the next read is decoded. mem_access muxes its BRAM address on wr_en, so rd_addr must remain stable through WAIT_CPL.
- A tlast arriving earlier than the format requires aborts the request to IDLE: no strobe, no completion.
- Reset values:
  - State IDLE; tready = 0 during reset.
  - wr_en = 0, req_compl = 0.
  - All address, data and field outputs = 0.

## Timing
- tready is a function of state only, with no combinational path from inputs.
  - High in IDLE, RD32, RD64, WR32, WR64A, WR64B and DISCARD.
  - Low in WAIT_WR and WAIT_CPL.
  - Low while rst is asserted; high from the first clk edge after release.
- 3DW write, header accepted at edge T, beat 1 at T+1:
  - wr_en high during cycle T+1..T+2; exactly one cycle if wr_busy = 0.
  - tready high again the cycle after wr_en falls.
- 4DW write: add one cycle relative to the 3DW case.
- 3DW read, beat 1 accepted at T+1: rd_addr and req_compl valid from the cycle after T+1.
- compl_done sampled high → req_compl low and tready high on the next cycle.
- compl_done outside WAIT_CPL is ignored.
- A second TLP presented during a wait is stalled (tready = 0), never lost.
- rst asserted mid-TLP: outputs return to reset values immediately; the remainder of the TLP after release is treated as a new header.

## Test plan
- MemWr32, BAR2 hit, addr 0x0000_0010, firstBE 0xF, data 0x11223344 → one wr_en pulse with wr_addr = 0x2004, wr_data = 0x44332211, wr_be = 0x0F.
- MemRd32, BAR0 hit, addr 0x04, tag 0x5A, RID 0x0100 → rd_addr = 0x1001, req_compl held with req_tag = 0x5A, req_len = 1; tready = 0 until compl_done, then high the next cycle.
- MemWr64, BAR2 hit, addr 0x0000_0000_0000_0020, wr_busy high for 3 cycles → wr_en high for 4 cycles, then wr_addr = 0x2008 and tready returns.
- Completion TLP (type 01010) of 3 beats, then MemRd32 back-to-back → first TLP dropped with no outputs; the read is decoded normally.
- MemWr32 with length 2 → discarded, no wr_en.
- Same TLP with tlast on beat 0 → no wr_en; engine back in IDLE.
- rst asserted during WAIT_CPL → req_compl = 0 and tready = 0 while rst is asserted; after release the next MemRd32 completes normally.
